commit_wide: RTL and testbench

Parametrised N-wide in-order retirement unit between the ROB head window and the architectural register file, branch predictor, JALR queue and store path. Each cycle it retires 0..WIDTH consecutive ready entries and drives one register-file write lane per slot. A small FSM serialises store retirement through a req/done handshake and runs a fixed-length flush sequence after a mispredicted branch. Retirement and mispredict performance counters are kept in the block.

---
 rtl/commit_wide_pkg.sv | 46 ++++
 rtl/commit_wide_select.sv | 70 +++++++
 rtl/commit_wide.sv | 210 +++++++++++++++++++++
 tb/tb_commit_wide.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_wide_pkg.sv
// Shared types for the commit_wide retirement unit: ROB entry and CDB packet layouts,
// instruction-type encodings, FSM state and group-end reason enums.
package commit_wide_pkg;

    localparam int ROB_TAG_W = 4;

    localparam logic [1:0] ITYPE_BRANCH = 2'b00;
    localparam logic [1:0] ITYPE_STORE  = 2'b01;

    // Branch entries reuse destination as the branch PC and value as the sign-extended immediate.
    typedef struct packed {
        logic [1:0]           itype;
        logic [ROB_TAG_W-1:0] tag;
        logic [31:0]          destination;
        logic [31:0]          value;
        logic                 branch_pred;
        logic                 branch_result;
        logic                 is_jalr;
        logic [3:0]           ras_pointer;
    } ROB_entry_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] dest_ROB_entry;
        logic [31:0]          value;
        logic                 branch_result;
        logic                 load_step1;
        logic                 from_commit;
    } CDB_packet_t;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH      = 2'd2
    } commit_state_t;

    typedef enum logic [2:0] {
        END_NONE      = 3'd0,
        END_IDLE      = 3'd1,
        END_NOT_READY = 3'd2,
        END_BRANCH    = 3'd3,
        END_JALR      = 3'd4,
        END_MISPRED   = 3'd5,
        END_STORE     = 3'd6
    } end_reason_t;

endpackage

// File: rtl/commit_wide_select.sv
// Per-slot commit mask: a slot retires only if every older slot retires and no
// group-ending rule (branch/JALR limits, mispredict, store) stops it.
module commit_select
    import commit_wide_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int CNT_IN_W = 5
) (
    input  logic                run,
    input  logic [WIDTH-1:0]    head_ready,
    input  logic [WIDTH-1:0]    is_branch,
    input  logic [WIDTH-1:0]    is_store,
    input  logic [WIDTH-1:0]    is_jalr,
    input  logic [WIDTH-1:0]    is_mispred,
    input  logic [CNT_IN_W-1:0] rob_count,
    input  logic                jalrq_ready,
    output logic [WIDTH-1:0]    commit_mask,
    output end_reason_t         end_reason,
    output logic                store_at_head
);

    logic alive;
    logic seen_branch;
    logic seen_jalr;
    logic slot_ok;

    always_comb begin
        commit_mask = '0;
        end_reason  = run ? END_NONE : END_IDLE;
        alive       = run;
        seen_branch = 1'b0;
        seen_jalr   = 1'b0;
        slot_ok     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            slot_ok = alive;
            if (alive) begin
                if (CNT_IN_W'(i) >= rob_count) begin
                    slot_ok    = 1'b0;
                    end_reason = END_IDLE;
                end else if (!head_ready[i]) begin
                    slot_ok    = 1'b0;
                    end_reason = END_NOT_READY;
                end else if (is_store[i]) begin
                    slot_ok    = 1'b0;
                    end_reason = END_STORE;
                end else if (is_branch[i] && seen_branch) begin
                    slot_ok    = 1'b0;
                    end_reason = END_BRANCH;
                end else if (is_jalr[i] && (seen_jalr || !jalrq_ready)) begin
                    slot_ok    = 1'b0;
                    end_reason = END_JALR;
                end
            end
            commit_mask[i] = slot_ok;
            if (slot_ok) begin
                seen_branch = seen_branch | is_branch[i];
                seen_jalr   = seen_jalr | is_jalr[i];
                // A mispredicted branch retires itself but nothing younger.
                if (is_mispred[i]) begin
                    alive      = 1'b0;
                    end_reason = END_MISPRED;
                end
            end else begin
                alive = 1'b0;
            end
        end
        store_at_head = run && (rob_count != '0) && head_ready[0] && is_store[0];
    end

endmodule

// File: rtl/commit_wide.sv
// N-wide in-order retirement: per-lane register writes, branch predictor update,
// serialised store commit via req/done, fixed-length flush after a mispredict.
module commit_wide
    import commit_wide_pkg::*;
#(
    parameter int WIDTH        = 2,
    parameter int ROB_IDX_W    = ROB_TAG_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  ROB_entry_t [WIDTH-1:0]            head,
    input  logic [WIDTH-1:0]                  head_ready,
    input  logic [ROB_IDX_W:0]                rob_count,
    input  logic                              jalrq_ready,
    input  logic                              store_done,
    output logic [$clog2(WIDTH+1)-1:0]        rd_count,
    output logic                              rd_en_jalrq,
    output logic [WIDTH-1:0]                  RegWrite,
    output logic [WIDTH-1:0][4:0]             rd,
    output logic [WIDTH-1:0][31:0]            WriteData,
    output logic [WIDTH-1:0][ROB_IDX_W-1:0]   commit_ROB,
    output CDB_packet_t [WIDTH-1:0]           commit_packet,
    output logic                              commit_is_branch,
    output logic                              commit_prediction,
    output logic                              commit_result,
    output logic [31:0]                       committed_pc,
    output logic [31:0]                       commit_imm_se,
    output logic [3:0]                        commit_ras_pointer,
    output logic                              store_commit_req,
    output logic                              flush,
    output logic [31:0]                       flush_pc,
    output logic [CNT_W-1:0]                  retired_cnt,
    output logic [CNT_W-1:0]                  mispredict_cnt,
    output commit_state_t                     dbg_state,
    output end_reason_t                       dbg_end_reason
);

    localparam int RC_W = $clog2(WIDTH+1);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    commit_state_t    state_q, state_d;
    logic             flush_q, flush_d;
    logic [31:0]      flush_pc_q, flush_pc_d;
    logic             store_req_q, store_req_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    logic [WIDTH-1:0] is_branch, is_store, is_jalr, is_mispred, commit_mask;
    logic             store_at_head, store_fire, lane_fire, mispred_commit;
    logic [31:0]      flush_target;
    logic [RC_W-1:0]  rd_count_w;

    always_comb begin
        is_branch  = '0;
        is_store   = '0;
        is_jalr    = '0;
        is_mispred = '0;
        for (int i = 0; i < WIDTH; i++) begin
            is_branch[i]  = (head[i].itype == ITYPE_BRANCH);
            is_store[i]   = (head[i].itype == ITYPE_STORE);
            is_jalr[i]    = head[i].itype[1] && head[i].is_jalr;
            is_mispred[i] = is_branch[i] && (head[i].branch_pred != head[i].branch_result);
        end
    end

    commit_select #(
        .WIDTH    (WIDTH),
        .CNT_IN_W (ROB_IDX_W+1)
    ) u_select (
        .run           (state_q == ST_RUN),
        .head_ready    (head_ready),
        .is_branch     (is_branch),
        .is_store      (is_store),
        .is_jalr       (is_jalr),
        .is_mispred    (is_mispred),
        .rob_count     (rob_count),
        .jalrq_ready   (jalrq_ready),
        .commit_mask   (commit_mask),
        .end_reason    (dbg_end_reason),
        .store_at_head (store_at_head)
    );

    // Store handshake: store_commit_req is held high for the whole STORE_WAIT state;
    // a single-cycle store_done completes it and the store retires in that same cycle.
    assign store_fire = (state_q == ST_STORE_WAIT) && store_done;

    always_comb begin
        RegWrite           = '0;
        rd                 = '0;
        WriteData          = '0;
        commit_ROB         = '0;
        commit_packet      = '0;
        commit_is_branch   = 1'b0;
        commit_prediction  = 1'b0;
        commit_result      = 1'b0;
        committed_pc       = '0;
        commit_imm_se      = '0;
        commit_ras_pointer = '0;
        rd_en_jalrq        = 1'b0;
        mispred_commit     = 1'b0;
        flush_target       = '0;
        rd_count_w         = '0;
        lane_fire          = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_fire = commit_mask[i] || ((i == 0) && store_fire);
            if (lane_fire) begin
                rd_count_w                 = rd_count_w + RC_W'(1);
                commit_ROB[i]              = ROB_IDX_W'(head[i].tag);
                commit_packet[i].from_commit = 1'b1;
                commit_ras_pointer         = head[i].ras_pointer;
                if (head[i].itype[1]) begin
                    RegWrite[i]                     = 1'b1;
                    rd[i]                           = head[i].destination[4:0];
                    WriteData[i]                    = head[i].value;
                    commit_packet[i].dest_ROB_entry = head[i].tag;
                    commit_packet[i].value          = head[i].value;
                end
                if (is_branch[i]) begin
                    commit_is_branch  = 1'b1;
                    commit_prediction = head[i].branch_pred;
                    commit_result     = head[i].branch_result;
                    committed_pc      = head[i].destination;
                    commit_imm_se     = head[i].value;
                    if (is_mispred[i]) begin
                        mispred_commit = 1'b1;
                        flush_target   = head[i].branch_result
                                       ? head[i].destination + head[i].value
                                       : head[i].destination + 32'd4;
                    end
                end
                if (is_jalr[i]) begin
                    rd_en_jalrq = 1'b1;
                end
            end
        end
        rd_count = rd_count_w;
    end

    always_comb begin
        state_d     = state_q;
        flush_d     = 1'b0;
        flush_pc_d  = flush_pc_q;
        store_req_d = store_req_q;
        fcnt_d      = fcnt_q;
        retired_d   = retired_q + CNT_W'(rd_count_w);
        mispred_d   = mispred_q + CNT_W'(mispred_commit);
        case (state_q)
            ST_RUN: begin
                if (mispred_commit) begin
                    state_d    = ST_FLUSH;
                    flush_d    = 1'b1;
                    flush_pc_d = flush_target;
                    fcnt_d     = FC_W'(FLUSH_CYCLES - 1);
                end else if (store_at_head) begin
                    state_d     = ST_STORE_WAIT;
                    store_req_d = 1'b1;
                end
            end
            ST_STORE_WAIT: begin
                if (store_done) begin
                    state_d     = ST_RUN;
                    store_req_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                // The flush pulse cycle is the first of the frozen cycles.
                if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d     = ST_RUN;
                store_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_q     <= 1'b0;
            flush_pc_q  <= '0;
            store_req_q <= 1'b0;
            fcnt_q      <= '0;
            retired_q   <= '0;
            mispred_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            flush_pc_q  <= flush_pc_d;
            store_req_q <= store_req_d;
            fcnt_q      <= fcnt_d;
            retired_q   <= retired_d;
            mispred_q   <= mispred_d;
        end
    end

    assign store_commit_req = store_req_q;
    assign flush            = flush_q;
    assign flush_pc         = flush_pc_q;
    assign retired_cnt      = retired_q;
    assign mispredict_cnt   = mispred_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_commit_wide.sv
// Directed bench for commit_wide (WIDTH=2): register retirement, partial groups,
// store handshake, mispredict flush, JALR gating and reset during STORE_WAIT.
module tb_commit_wide;
    import commit_wide_pkg::*;

    localparam int WIDTH        = 2;
    localparam int ROB_IDX_W    = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;

    logic                            clk;
    logic                            rst_n;
    ROB_entry_t [WIDTH-1:0]          head;
    logic [WIDTH-1:0]                head_ready;
    logic [ROB_IDX_W:0]              rob_count;
    logic                            jalrq_ready;
    logic                            store_done;
    logic [1:0]                      rd_count;
    logic                            rd_en_jalrq;
    logic [WIDTH-1:0]                RegWrite;
    logic [WIDTH-1:0][4:0]           rd;
    logic [WIDTH-1:0][31:0]          WriteData;
    logic [WIDTH-1:0][ROB_IDX_W-1:0] commit_ROB;
    CDB_packet_t [WIDTH-1:0]         commit_packet;
    logic                            commit_is_branch;
    logic                            commit_prediction;
    logic                            commit_result;
    logic [31:0]                     committed_pc;
    logic [31:0]                     commit_imm_se;
    logic [3:0]                      commit_ras_pointer;
    logic                            store_commit_req;
    logic                            flush;
    logic [31:0]                     flush_pc;
    logic [CNT_W-1:0]                retired_cnt;
    logic [CNT_W-1:0]                mispredict_cnt;
    commit_state_t                   dbg_state;
    end_reason_t                     dbg_end_reason;

    int checks;
    int errors;

    commit_wide #(
        .WIDTH        (WIDTH),
        .ROB_IDX_W    (ROB_IDX_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .head               (head),
        .head_ready         (head_ready),
        .rob_count          (rob_count),
        .jalrq_ready        (jalrq_ready),
        .store_done         (store_done),
        .rd_count           (rd_count),
        .rd_en_jalrq        (rd_en_jalrq),
        .RegWrite           (RegWrite),
        .rd                 (rd),
        .WriteData          (WriteData),
        .commit_ROB         (commit_ROB),
        .commit_packet      (commit_packet),
        .commit_is_branch   (commit_is_branch),
        .commit_prediction  (commit_prediction),
        .commit_result      (commit_result),
        .committed_pc       (committed_pc),
        .commit_imm_se      (commit_imm_se),
        .commit_ras_pointer (commit_ras_pointer),
        .store_commit_req   (store_commit_req),
        .flush              (flush),
        .flush_pc           (flush_pc),
        .retired_cnt        (retired_cnt),
        .mispredict_cnt     (mispredict_cnt),
        .dbg_state          (dbg_state),
        .dbg_end_reason     (dbg_end_reason)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry builders
    function automatic ROB_entry_t mk_reg(input logic [3:0] tag, input logic [4:0] rdn,
                                          input logic [31:0] val, input logic [3:0] ras);
        ROB_entry_t e;
        e = '0;
        e.itype = 2'b10;
        e.tag = tag;
        e.destination = {27'd0, rdn};
        e.value = val;
        e.ras_pointer = ras;
        return e;
    endfunction

    function automatic ROB_entry_t mk_branch(input logic [3:0] tag, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic pred, input logic res);
        ROB_entry_t e;
        e = '0;
        e.itype = ITYPE_BRANCH;
        e.tag = tag;
        e.destination = pc;
        e.value = imm;
        e.branch_pred = pred;
        e.branch_result = res;
        return e;
    endfunction

    function automatic ROB_entry_t mk_store(input logic [3:0] tag);
        ROB_entry_t e;
        e = '0;
        e.itype = ITYPE_STORE;
        e.tag = tag;
        return e;
    endfunction

    task automatic set_idle();
        head = '0;
        head_ready = '0;
        rob_count = '0;
        jalrq_ready = 1'b0;
        store_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
        checks++; if (flush_pc !== 32'h0) begin errors++; $display("FAIL reset_flush_pc got %h exp 0", flush_pc); end
        checks++; if (store_commit_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", store_commit_req); end
        checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired_cnt); end
        checks++; if (mispredict_cnt !== 32'd0) begin errors++; $display("FAIL reset_mispred got %0d exp 0", mispredict_cnt); end
        checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        checks++; if (rd_count !== 2'd0) begin errors++; $display("FAIL reset_rd_count got %0d exp 0", rd_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_two_reg();
        head[0] = mk_reg(4'd1, 5'd5, 32'h11, 4'd0);
        head[1] = mk_reg(4'd2, 5'd6, 32'h22, 4'd0);
        head_ready = 2'b11;
        rob_count = 5'd2;
        #1;
        checks++; if (rd_count !== 2'd2) begin errors++; $display("FAIL two_reg_rd_count got %0d exp 2", rd_count); end
        checks++; if (RegWrite !== 2'b11) begin errors++; $display("FAIL two_reg_regwrite got %b exp 11", RegWrite); end
        checks++; if (rd[0] !== 5'd5 || rd[1] !== 5'd6) begin errors++; $display("FAIL two_reg_rd got %0d,%0d exp 5,6", rd[0], rd[1]); end
        checks++; if (WriteData[0] !== 32'h11 || WriteData[1] !== 32'h22) begin errors++; $display("FAIL two_reg_wdata got %h,%h exp 11,22", WriteData[0], WriteData[1]); end
        checks++; if (commit_ROB[0] !== 4'd1 || commit_ROB[1] !== 4'd2) begin errors++; $display("FAIL two_reg_tags got %0d,%0d exp 1,2", commit_ROB[0], commit_ROB[1]); end
        checks++; if (commit_packet[1].from_commit !== 1'b1 || commit_packet[1].dest_ROB_entry !== 4'd2) begin errors++; $display("FAIL two_reg_packet got fc=%b dest=%0d exp 1,2", commit_packet[1].from_commit, commit_packet[1].dest_ROB_entry); end
        @(negedge clk);
        checks++; if (retired_cnt !== 32'd2) begin errors++; $display("FAIL two_reg_retired got %0d exp 2", retired_cnt); end
        set_idle();
    endtask

    task automatic test_partial();
        head[0] = mk_reg(4'd3, 5'd7, 32'h33, 4'd0);
        head[1] = mk_reg(4'd4, 5'd8, 32'h44, 4'd0);
        head_ready = 2'b01;
        rob_count = 5'd2;
        #1;
        checks++; if (rd_count !== 2'd1) begin errors++; $display("FAIL partial_rd_count got %0d exp 1", rd_count); end
        checks++; if (RegWrite !== 2'b01 || commit_ROB[1] !== 4'd0) begin errors++; $display("FAIL partial_lanes got %b tag1=%0d exp 01,0", RegWrite, commit_ROB[1]); end
        @(negedge clk);
        head_ready = 2'b11;
        rob_count = 5'd0;
        #1;
        checks++; if (rd_count !== 2'd0 || RegWrite !== 2'b00 || commit_ROB !== '0 || commit_packet !== '0 || WriteData !== '0) begin
            errors++; $display("FAIL empty_rob got rd_count=%0d regwrite=%b exp all zero", rd_count, RegWrite); end
        @(negedge clk);
        rob_count = 5'd1;
        #1;
        checks++; if (rd_count !== 2'd1 || RegWrite !== 2'b01) begin errors++; $display("FAIL rob_count_one got %0d,%b exp 1,01", rd_count, RegWrite); end
        @(negedge clk);
        checks++; if (retired_cnt !== 32'd4) begin errors++; $display("FAIL partial_retired got %0d exp 4", retired_cnt); end
        set_idle();
    endtask

    task automatic test_store();
        head[0] = mk_store(4'd3);
        head[1] = mk_reg(4'd4, 5'd9, 32'h55, 4'd0);
        head_ready = 2'b11;
        rob_count = 5'd2;
        #1;
        checks++; if (rd_count !== 2'd0 || store_commit_req !== 1'b0) begin errors++; $display("FAIL store_run got rd_count=%0d req=%b exp 0,0", rd_count, store_commit_req); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (store_commit_req !== 1'b1 || rd_count !== 2'd0 || dbg_state !== ST_STORE_WAIT) begin
                errors++; $display("FAIL store_wait cycle %0d got req=%b rd_count=%0d state=%0d exp 1,0,1", c, store_commit_req, rd_count, dbg_state); end
        end
        store_done = 1'b1;
        #1;
        checks++; if (rd_count !== 2'd1 || commit_ROB[0] !== 4'd3 || RegWrite !== 2'b00) begin
            errors++; $display("FAIL store_done got rd_count=%0d tag=%0d regwrite=%b exp 1,3,00", rd_count, commit_ROB[0], RegWrite); end
        @(negedge clk);
        checks++; if (dbg_state !== ST_RUN || store_commit_req !== 1'b0 || retired_cnt !== 32'd5) begin
            errors++; $display("FAIL store_after got state=%0d req=%b retired=%0d exp 0,0,5", dbg_state, store_commit_req, retired_cnt); end
        set_idle();
    endtask

    task automatic test_mispredict();
        head[0] = mk_branch(4'd4, 32'h100, 32'h40, 1'b0, 1'b1);
        head[1] = mk_reg(4'd5, 5'd10, 32'h77, 4'd0);
        head_ready = 2'b11;
        rob_count = 5'd2;
        #1;
        checks++; if (rd_count !== 2'd1 || RegWrite !== 2'b00 || commit_ROB[0] !== 4'd4 || commit_ROB[1] !== 4'd0) begin
            errors++; $display("FAIL mispred_group got rd_count=%0d regwrite=%b tags=%0d,%0d exp 1,00,4,0", rd_count, RegWrite, commit_ROB[0], commit_ROB[1]); end
        checks++; if (commit_is_branch !== 1'b1 || commit_prediction !== 1'b0 || commit_result !== 1'b1 || committed_pc !== 32'h100 || commit_imm_se !== 32'h40) begin
            errors++; $display("FAIL mispred_bp got br=%b p=%b r=%b pc=%h imm=%h exp 1,0,1,100,40", commit_is_branch, commit_prediction, commit_result, committed_pc, commit_imm_se); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mispred_early_flush got %b exp 0", flush); end
        @(negedge clk);
        checks++; if (flush !== 1'b1 || flush_pc !== 32'h140) begin errors++; $display("FAIL mispred_flush got flush=%b pc=%h exp 1,140", flush, flush_pc); end
        checks++; if (mispredict_cnt !== 32'd1 || retired_cnt !== 32'd6 || dbg_state !== ST_FLUSH) begin
            errors++; $display("FAIL mispred_cnt got mis=%0d ret=%0d state=%0d exp 1,6,2", mispredict_cnt, retired_cnt, dbg_state); end
        head[0] = mk_reg(4'd5, 5'd10, 32'h77, 4'd0);
        head[1] = mk_reg(4'd6, 5'd11, 32'h88, 4'd0);
        #1;
        checks++; if (rd_count !== 2'd0) begin errors++; $display("FAIL flush_frozen0 got %0d exp 0", rd_count); end
        @(negedge clk);
        checks++; if (flush !== 1'b0 || dbg_state !== ST_FLUSH || rd_count !== 2'd0) begin
            errors++; $display("FAIL flush_frozen1 got flush=%b state=%0d rd_count=%0d exp 0,2,0", flush, dbg_state, rd_count); end
        @(negedge clk);
        checks++; if (dbg_state !== ST_RUN || rd_count !== 2'd2) begin errors++; $display("FAIL flush_resume got state=%0d rd_count=%0d exp 0,2", dbg_state, rd_count); end
        set_idle();
    endtask

    task automatic test_branch_limit();
        head[0] = mk_branch(4'd9, 32'h200, 32'h8, 1'b1, 1'b1);
        head[1] = mk_branch(4'd10, 32'h300, 32'h8, 1'b0, 1'b0);
        head_ready = 2'b11;
        rob_count = 5'd2;
        #1;
        checks++; if (rd_count !== 2'd1 || commit_ROB[1] !== 4'd0 || committed_pc !== 32'h200) begin
            errors++; $display("FAIL one_branch got rd_count=%0d tag1=%0d pc=%h exp 1,0,200", rd_count, commit_ROB[1], committed_pc); end
        @(negedge clk);
        checks++; if (flush !== 1'b0 || mispredict_cnt !== 32'd1 || retired_cnt !== 32'd7) begin
            errors++; $display("FAIL good_branch got flush=%b mis=%0d ret=%0d exp 0,1,7", flush, mispredict_cnt, retired_cnt); end
        set_idle();
        head[0] = mk_branch(4'd11, 32'hFFFF_FFFE, 32'h10, 1'b1, 1'b0);
        head_ready = 2'b01;
        rob_count = 5'd1;
        @(negedge clk);
        set_idle();
        checks++; if (flush !== 1'b1 || flush_pc !== 32'h2 || mispredict_cnt !== 32'd2) begin
            errors++; $display("FAIL flush_wrap got flush=%b pc=%h mis=%0d exp 1,2,2", flush, flush_pc, mispredict_cnt); end
        repeat (2) @(negedge clk);
        checks++; if (dbg_state !== ST_RUN || retired_cnt !== 32'd8) begin errors++; $display("FAIL wrap_resume got state=%0d ret=%0d exp 0,8", dbg_state, retired_cnt); end
    endtask

    task automatic test_jalr();
        head[0] = mk_reg(4'd12, 5'd1, 32'h1000, 4'd3);
        head[0].is_jalr = 1'b1;
        head[1] = mk_reg(4'd13, 5'd2, 32'h2000, 4'd5);
        head_ready = 2'b11;
        rob_count = 5'd2;
        jalrq_ready = 1'b0;
        #1;
        checks++; if (rd_count !== 2'd0 || rd_en_jalrq !== 1'b0 || RegWrite !== 2'b00) begin
            errors++; $display("FAIL jalr_blocked got rd_count=%0d deq=%b exp 0,0", rd_count, rd_en_jalrq); end
        @(negedge clk);
        jalrq_ready = 1'b1;
        #1;
        checks++; if (rd_count !== 2'd2 || rd_en_jalrq !== 1'b1 || commit_ras_pointer !== 4'd5 || WriteData[0] !== 32'h1000) begin
            errors++; $display("FAIL jalr_go got rd_count=%0d deq=%b ras=%0d exp 2,1,5", rd_count, rd_en_jalrq, commit_ras_pointer); end
        @(negedge clk);
        checks++; if (retired_cnt !== 32'd10) begin errors++; $display("FAIL jalr_retired got %0d exp 10", retired_cnt); end
        head[0] = mk_reg(4'd14, 5'd1, 32'h3000, 4'd2);
        head[0].is_jalr = 1'b1;
        head[1] = mk_reg(4'd15, 5'd1, 32'h4000, 4'd4);
        head[1].is_jalr = 1'b1;
        #1;
        checks++; if (rd_count !== 2'd1 || commit_ras_pointer !== 4'd2 || rd_en_jalrq !== 1'b1) begin
            errors++; $display("FAIL two_jalr got rd_count=%0d ras=%0d deq=%b exp 1,2,1", rd_count, commit_ras_pointer, rd_en_jalrq); end
        @(negedge clk);
        checks++; if (retired_cnt !== 32'd11) begin errors++; $display("FAIL two_jalr_retired got %0d exp 11", retired_cnt); end
        set_idle();
    endtask

    task automatic test_reset_store_wait();
        head[0] = mk_store(4'd7);
        head_ready = 2'b01;
        rob_count = 5'd1;
        @(negedge clk);
        checks++; if (store_commit_req !== 1'b1) begin errors++; $display("FAIL rst_sw_enter got %b exp 1", store_commit_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (store_commit_req !== 1'b0 || retired_cnt !== 32'd0 || mispredict_cnt !== 32'd0 || flush_pc !== 32'h0 || dbg_state !== ST_RUN) begin
            errors++; $display("FAIL rst_sw_async got req=%b ret=%0d mis=%0d pc=%h state=%0d exp 0,0,0,0,0", store_commit_req, retired_cnt, mispredict_cnt, flush_pc, dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        @(negedge clk);
        checks++; if (dbg_state !== ST_RUN || store_commit_req !== 1'b0) begin errors++; $display("FAIL rst_sw_release got state=%0d req=%b exp 0,0", dbg_state, store_commit_req); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_two_reg();
        test_partial();
        test_store();
        test_mispredict();
        test_branch_limit();
        test_jalr();
        test_reset_store_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
